// File: rtl/rv32i_types_pkg.sv
// Shared types for the instruction fetch path: fetch FSM states and
// the halfword encoding helper used to spot compressed instructions.
package rv32i_types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [1:0] HW_COMPRESSED_MASK = 2'b11;

    // A halfword starts a 16-bit instruction unless both low bits are set.
    function automatic logic is_compressed(input logic [15:0] hw);
        return (hw[1:0] & HW_COMPRESSED_MASK) != HW_COMPRESSED_MASK;
    endfunction

endpackage

// File: rtl/fetch_align_buffer_if.sv
// Bundles the instruction-memory port, the redirect input and the decode
// handshake of the fetch/align buffer.
interface fetch_align_buffer_if #(
    parameter int DEPTH_HW = 8
) ();
    localparam int OCC_W = $clog2(DEPTH_HW) + 1;

    logic [31:0]      imem_addr;
    logic             imem_ren;
    logic             imem_busy;
    logic [31:0]      imem_rdata;
    logic             flush;
    logic [31:0]      flush_pc;
    logic [31:0]      instr;
    logic [31:0]      instr_pc;
    logic             instr_compressed;
    logic             instr_valid;
    logic             instr_ready;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output imem_addr, imem_ren,
        input  imem_busy, imem_rdata,
        input  flush, flush_pc,
        output instr, instr_pc, instr_compressed, instr_valid,
        input  instr_ready,
        output occupancy
    );

    modport slave (
        input  imem_addr, imem_ren,
        output imem_busy, imem_rdata,
        output flush, flush_pc,
        input  instr, instr_pc, instr_compressed, instr_valid,
        output instr_ready,
        input  occupancy
    );
endinterface

// File: rtl/halfword_fifo.sv
// Circular halfword store: pushes and pops one or two halfwords per cycle,
// exposes the two entries at the head, synchronous clear on redirect.
module halfword_fifo #(
    parameter int DEPTH_HW = 8,
    localparam int PTR_W   = $clog2(DEPTH_HW),
    localparam int OCC_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [1:0]       push_cnt,
    input  logic [15:0]      push_hw0,
    input  logic [15:0]      push_hw1,
    input  logic [1:0]       pop_cnt,
    output logic [15:0]      head_hw0,
    output logic [15:0]      head_hw1,
    output logic [OCC_W-1:0] occupancy
);

    logic [15:0]      mem [DEPTH_HW];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [OCC_W-1:0] count;

    assign rd_ptr_p1 = rd_ptr + 1'b1;
    assign wr_ptr_p1 = wr_ptr + 1'b1;

    // Storage is zeroed on reset so the head reads as zero before any fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_HW; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem[wr_ptr] <= push_hw0;
            end
            if (push_cnt == 2'd2) begin
                mem[wr_ptr_p1] <= push_hw1;
            end
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            count  <= count + OCC_W'(push_cnt) - OCC_W'(pop_cnt);
        end
    end

    assign head_hw0  = mem[rd_ptr];
    assign head_hw1  = mem[rd_ptr_p1];
    assign occupancy = count;

endmodule

// File: rtl/fetch_align_buffer.sv
// Fetches aligned words from instruction memory, splits them into halfwords
// and presents one 16- or 32-bit instruction per decode handshake.
module fetch_align_buffer
    import rv32i_types_pkg::*;
#(
    parameter int          DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic                 CLK,
    input  logic                 RST,
    fetch_align_buffer_if.master bus
);

    localparam int               OCC_W   = $clog2(DEPTH_HW) + 1;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH_HW);

    fetch_state_t     state, state_n;
    logic [31:0]      fetch_pc, fetch_pc_n;
    logic [31:0]      drop_addr, drop_addr_n;
    logic [31:0]      head_pc;
    logic [31:0]      req_addr;
    logic [31:0]      redirect_pc;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] free;
    logic [OCC_W-1:0] push_n;
    logic [1:0]       push_cnt;
    logic [1:0]       pop_cnt;
    logic [15:0]      hw0, hw1;
    logic             comp;
    logic             valid;
    logic             pop_fire;
    logic             unused_pc_bits;

    assign unused_pc_bits = bus.flush_pc[0] ^ fetch_pc[0];

    assign req_addr    = {fetch_pc[31:2], 2'b00};
    assign redirect_pc = {bus.flush_pc[31:1], 1'b0};
    assign free        = DEPTH_V - occ;
    assign push_n      = fetch_pc[1] ? OCC_W'(1) : OCC_W'(2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            drop_addr <= drop_addr_n;
        end
    end

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        drop_addr_n   = drop_addr;
        bus.imem_ren  = 1'b0;
        bus.imem_addr = req_addr;
        push_cnt      = 2'd0;
        case (state)
            IDLE: begin
                if (!bus.flush && free >= OCC_W'(2)) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                bus.imem_ren = 1'b1;
                if (bus.flush) begin
                    // Remember the outstanding address so it stays on the bus while draining.
                    state_n     = bus.imem_busy ? DROP : IDLE;
                    drop_addr_n = req_addr;
                end else if (!bus.imem_busy) begin
                    push_cnt   = fetch_pc[1] ? 2'd1 : 2'd2;
                    fetch_pc_n = req_addr + 32'd4;
                    state_n    = ((free - push_n) >= OCC_W'(2)) ? REQ : IDLE;
                end
            end
            DROP: begin
                bus.imem_ren  = 1'b1;
                bus.imem_addr = drop_addr;
                if (!bus.imem_busy && !bus.flush) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (bus.flush) begin
            fetch_pc_n = redirect_pc;
        end
    end

    halfword_fifo #(
        .DEPTH_HW(DEPTH_HW)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .clear     (bus.flush),
        .push_cnt  (push_cnt),
        .push_hw0  (fetch_pc[1] ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0]),
        .push_hw1  (bus.imem_rdata[31:16]),
        .pop_cnt   (pop_cnt),
        .head_hw0  (hw0),
        .head_hw1  (hw1),
        .occupancy (occ)
    );

    // A full instruction needs both halves buffered; no partial output.
    assign comp     = is_compressed(hw0);
    assign valid    = comp ? (occ != '0) : (occ >= OCC_W'(2));
    assign pop_fire = valid && bus.instr_ready && !bus.flush;
    assign pop_cnt  = pop_fire ? (comp ? 2'd1 : 2'd2) : 2'd0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_pc <= RESET_PC;
        end else if (bus.flush) begin
            head_pc <= redirect_pc;
        end else if (pop_fire) begin
            head_pc <= head_pc + (comp ? 32'd2 : 32'd4);
        end
    end

    assign bus.instr            = comp ? {16'h0000, hw0} : {hw1, hw0};
    assign bus.instr_pc         = head_pc;
    assign bus.instr_compressed = comp;
    assign bus.instr_valid      = valid;
    assign bus.occupancy        = occ;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: aligned, compressed, straddling,
// flush-while-busy, backpressure and reset-mid-request sequences.
module tb_fetch_align_buffer;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } rec_t;

    logic        clk;
    logic        rst;
    logic [31:0] mem [256];
    rec_t        q[$];
    int          checks;
    int          errors;

    fetch_align_buffer_if #(.DEPTH_HW(8)) bus ();

    fetch_align_buffer #(
        .DEPTH_HW (8),
        .RESET_PC (32'h0000_0200)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every instruction decode accepts, in order.
    always @(posedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready && !bus.flush) begin
            q.push_back('{instr: bus.instr, pc: bus.instr_pc, comp: bus.instr_compressed});
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0000_0013 | (32'(i) << 20);
        end
    endtask

    task automatic do_reset(input logic ready);
        bus.instr_ready = ready;
        bus.imem_busy   = 1'b0;
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        rst = 1'b1;
        tick();
        tick();
        q.delete();
        chk("rst_ren",   32'(bus.imem_ren),    32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr,            32'd0);
        chk("rst_occ",   32'(bus.occupancy),   32'd0);
        chk("rst_pc",    bus.instr_pc,         32'h200);
        rst = 1'b0;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic e_c);
        rec_t r;
        int   n;
        n = 0;
        while (q.size() == 0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL %s_timeout: observed no instruction expected %h", tag, e_instr);
        end
        if (q.size() != 0) begin
            r = q.pop_front();
            chk({tag, "_instr"}, r.instr, e_instr);
            chk({tag, "_pc"},    r.pc,    e_pc);
            chk({tag, "_comp"},  32'(r.comp), 32'(e_c));
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.instr_ready = 1'b0;
        bus.imem_busy   = 1'b0;
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        init_mem();
        @(negedge clk);

        // Aligned sequential fetch
        mem[8'h80] = 32'h0050_0093;
        mem[8'h81] = 32'h0010_8113;
        do_reset(1'b1);
        tick();
        chk("t1_ren",  32'(bus.imem_ren), 32'd1);
        chk("t1_addr", bus.imem_addr,     32'h200);
        expect_instr("t1_a", 32'h0050_0093, 32'h200, 1'b0);
        expect_instr("t1_b", 32'h0010_8113, 32'h204, 1'b0);

        // Compressed pair in one word
        init_mem();
        mem[8'h80] = 32'h4505_0001;
        do_reset(1'b1);
        expect_instr("t2_a", 32'h0000_0001, 32'h200, 1'b1);
        expect_instr("t2_b", 32'h0000_4505, 32'h202, 1'b1);

        // Full instruction straddling two words
        init_mem();
        mem[8'h80] = 32'h0093_0001;
        mem[8'h81] = 32'hABCD_0050;
        do_reset(1'b1);
        tick();
        tick();
        bus.imem_busy = 1'b1;
        tick();
        chk("t3_valid_wait", 32'(bus.instr_valid), 32'd0);
        chk("t3_occ_wait",   32'(bus.occupancy),   32'd1);
        chk("t3_addr_wait",  bus.imem_addr,        32'h204);
        tick();
        tick();
        tick();
        chk("t3_valid_hold", 32'(bus.instr_valid), 32'd0);
        chk("t3_addr_hold",  bus.imem_addr,        32'h204);
        bus.imem_busy = 1'b0;
        expect_instr("t3_a", 32'h0000_0001, 32'h200, 1'b1);
        expect_instr("t3_b", 32'h0050_0093, 32'h202, 1'b0);
        expect_instr("t3_c", 32'h0000_ABCD, 32'h206, 1'b1);

        // Flush while the 0x208 request is stalled
        init_mem();
        mem[8'h82] = 32'hDEAD_BEEF;
        mem[8'hC0] = 32'h4505_1111;
        do_reset(1'b1);
        tick();
        tick();
        tick();
        chk("t4_addr_208", bus.imem_addr, 32'h208);
        bus.imem_busy = 1'b1;
        tick();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h303;
        tick();
        bus.flush = 1'b0;
        chk("t4_drop_ren",   32'(bus.imem_ren),    32'd1);
        chk("t4_drop_addr",  bus.imem_addr,        32'h208);
        chk("t4_drop_occ",   32'(bus.occupancy),   32'd0);
        chk("t4_drop_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        tick();
        chk("t4_drop_hold", bus.imem_addr, 32'h208);
        bus.imem_busy = 1'b0;
        tick();
        chk("t4_idle_ren", 32'(bus.imem_ren), 32'd0);
        tick();
        chk("t4_redirect_addr", bus.imem_addr, 32'h300);
        expect_instr("t4_a", 32'h0800_0013, 32'h200, 1'b0);
        expect_instr("t4_b", 32'h0810_0013, 32'h204, 1'b0);
        expect_instr("t4_c", 32'h0000_4505, 32'h302, 1'b1);
        expect_instr("t4_d", 32'h0C10_0013, 32'h304, 1'b0);

        // Backpressure: buffer fills, fetching stops, nothing lost on release
        init_mem();
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("t5_occ_full", 32'(bus.occupancy),   32'd8);
        chk("t5_ren_off",  32'(bus.imem_ren),    32'd0);
        chk("t5_valid",    32'(bus.instr_valid), 32'd1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_instr($sformatf("t5_%0d", i), 32'h0000_0013 | (32'(8'h80 + i) << 20),
                         32'h200 + 32'(4 * i), 1'b0);
        end

        // Reset while a request is stalled
        init_mem();
        do_reset(1'b0);
        tick();
        tick();
        bus.imem_busy = 1'b1;
        tick();
        chk("t6_ren_pre",  32'(bus.imem_ren),  32'd1);
        chk("t6_addr_pre", bus.imem_addr,      32'h204);
        chk("t6_occ_pre",  32'(bus.occupancy), 32'd2);
        rst = 1'b1;
        tick();
        chk("t6_ren",   32'(bus.imem_ren),    32'd0);
        chk("t6_valid", 32'(bus.instr_valid), 32'd0);
        chk("t6_occ",   32'(bus.occupancy),   32'd0);
        rst           = 1'b0;
        bus.imem_busy = 1'b0;
        tick();
        chk("t6_ren_post",  32'(bus.imem_ren), 32'd1);
        chk("t6_addr_post", bus.imem_addr,     32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Instruction-side producer for the decode stage.
- Fetches aligned 32-bit words from instruction memory and buffers them as 16-bit halfwords.
- Presents one instruction per handshake to the control unit: either a full 32-bit instruction or a 16-bit compressed one.
- Compressed instructions are handed raw to the downstream decompressor. The block handles halfword-misaligned instructions that straddle words, and redirects on flush.

Parameters:
- DEPTH_HW, 8, halfword FIFO depth; power of 2, at least 4.
- RESET_PC, 32'h0000_0200, fetch PC loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are 0.
- imem_ren  out  1  read request; held with imem_addr until accepted.
- imem_busy  in  1  0 while imem_ren=1 means imem_rdata is valid this cycle and the request completes.
- imem_rdata  in  32  fetched word, little-endian halfwords.
- flush  in  1  redirect request; highest priority.
- flush_pc  in  32  redirect target; bit0 ignored.
- instr  out  32  head instruction; compressed form is {16'h0, hw}.
- instr_pc  out  32  PC of head instruction.
- instr_compressed  out  1  head halfword has [1:0] != 2'b11.
- instr_valid  out  1  a complete instruction is at the head.
- instr_ready  in  1  decode accepts the head.
- occupancy  out  $clog2(DEPTH_HW)+1  halfwords currently buffered.

Behaviour:
- Reset, synchronous active-high on RST:
  - State IDLE; fetch_pc = RESET_PC; head_pc = RESET_PC; FIFO empty.
  - imem_ren = 0, instr_valid = 0, instr = 0, occupancy = 0.
  - Reset mid-request abandons the bus transaction with no drop state.
- State machine (fetch_state_t):
  - IDLE -> REQ when free slots >= 2 and flush = 0.
  - REQ: imem_ren = 1, imem_addr = {fetch_pc[31:2], 2'b00}.
    - On imem_busy = 0, push halfwords: both if fetch_pc[1] = 0, upper only if fetch_pc[1] = 1.
    - Then fetch_pc <= imem_addr + 4.
    - Stay in REQ if free-after-push >= 2, else go to IDLE.
  - DROP: imem_ren held, imem_addr held at the stale address. On imem_busy = 0, discard the data and go to IDLE.
- Flush, in any state:
  - FIFO cleared.
  - fetch_pc and head_pc <= {flush_pc[31:1], 1'b0}.
  - Any pop that cycle is ignored.
  - REQ with imem_busy = 1 goes to DROP.
  - REQ with imem_busy = 0 discards the returning data and goes to IDLE.
  - DROP stays in DROP.
  - IDLE stays in IDLE; the request issues next cycle.
- Output logic, combinational from registered FIFO state:
  - hw0 = head and hw1 = head+1.
  - instr_compressed = (hw0[1:0] != 2'b11).
  - instr_valid = occupancy >= 1 when compressed, else occupancy >= 2.
  - instr = compressed ? {16'h0, hw0} : {hw1, hw0}.
  - In a flush cycle the outputs show pre-flush contents; decode qualifies them with flush.
- Pop on instr_valid & instr_ready & !flush:
  - Remove 1 halfword (compressed) or 2 (full).
  - head_pc += 2 or 4.
- Simultaneous push and pop are allowed. The space check uses the pre-pop occupancy, which is conservative, so the FIFO never overflows.
- Pointers wrap modulo DEPTH_HW. occupancy never exceeds DEPTH_HW.
- A 32-bit instruction whose lower half sits in the last slot is output only once the upper half has been pushed. No partial output.
- imem_addr and imem_ren stay stable while imem_busy = 1.

Decomposition:
- Shared package, in rv32i_types_pkg:
  - fetch_state_t {IDLE, REQ, DROP}.
  - Constant HW_COMPRESSED_MASK = 2'b11.
- Sub-module halfword_fifo: parameterised DEPTH_HW, 1-or-2 push, 1-or-2 pop, synchronous clear, occupancy output.
- The top level holds the FSM, the PCs and the output mux.

Test Plan:
- Aligned sequential fetch:
  - Stimulus: reset; mem[0x200] = 0x00500093, mem[0x204] = 0x00108113; instr_ready = 1; imem_busy = 0 always.
  - Required: first imem_addr = 0x200; outputs 0x00500093 at pc 0x200, then 0x00108113 at pc 0x204; instr_compressed = 0.
- Compressed pair:
  - Stimulus: mem[0x200] = 0x45050001.
  - Required: instr = 0x00000001 at pc 0x200, then 0x00004505 at pc 0x202; both instr_compressed = 1.
- Straddling instruction:
  - Stimulus: mem[0x200] = 0x00930001, mem[0x204] = 0xABCD0050.
  - Required: c.nop at 0x200, then 0x00500093 at pc 0x202. instr_valid stays 0 for the second instruction until the 0x204 word is pushed.
- Flush during busy:
  - Stimulus: hold imem_busy = 1 on the 0x208 request; pulse flush with flush_pc = 0x303.
  - Required: DROP state until busy falls; the stale word is never output; next imem_addr = 0x300; only its upper halfword is pushed; first instr_pc = 0x302.
- Backpressure:
  - Stimulus: instr_ready = 0 for 20 cycles.
  - Required: occupancy saturates at 8; imem_ren = 0 while free < 2; releasing ready yields all instructions in order with no loss or duplication.
- Reset mid-request:
  - Stimulus: assert RST for 1 cycle while in REQ with imem_busy = 1.
  - Required: next cycle imem_ren = 0, instr_valid = 0, occupancy = 0; the following request address is 0x200.
